// File: rtl/tcdm_error_pkg.sv
// Shared types and helpers for the TCDM error responder.
package tcdm_error_pkg;

  // Upper limits the log entry is sized for; a parameter check in the top keeps instances inside them.
  localparam int unsigned MAX_CH     = 32;
  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned CH_IDX_W   = 5;
  // Wide enough to hold a popcount of MAX_CH requests.
  localparam int unsigned HIT_CNT_W  = 6;

  // One captured offending access.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [CH_IDX_W-1:0]   ch;
    logic                  wen;
  } err_info_t;

  // Channel-index width for a given channel count; never narrower than one bit.
  function automatic int unsigned ch_idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // Add with saturation at max_val; a carry out of 32 bits also saturates.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/tcdm_error_resp_pipe.sv
// Per-channel response delay line: a LATENCY-deep valid shift register.
// One input pulse yields exactly one output pulse LATENCY cycles later, so
// back-to-back requests give back-to-back responses.
module tcdm_error_resp_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic valid_o
);

  logic [LATENCY-1:0] shift_q;

  // Shift accepted requests toward the output; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= (shift_q << 1) | LATENCY'(valid_i);
    end
  end

  assign valid_o = shift_q[LATENCY-1];

endmodule

// File: rtl/tcdm_error_slave_mc.sv
// Multi-channel TCDM error responder. Grants every request, returns an error
// response (r_opc = 1, rdata = ERROR_RESPONSE) RESP_LATENCY cycles later, and
// keeps a sticky log of the first offending access plus a saturating count of
// all offending accesses for software.
module tcdm_error_slave_mc
  import tcdm_error_pkg::*;
#(
  parameter int unsigned           NB_CH          = 1,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] ERROR_RESPONSE = 32'hBADACCE5,
  parameter int unsigned           RESP_LATENCY   = 1,
  parameter int unsigned           CNT_WIDTH      = 16,
  localparam int unsigned          CH_W           = ch_idx_width(NB_CH)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NB_CH-1:0]                     req_i,
  input  logic [NB_CH-1:0][ADDR_WIDTH-1:0]     add_i,
  input  logic [NB_CH-1:0]                     wen_i,
  output logic [NB_CH-1:0]                     gnt_o,
  output logic [NB_CH-1:0]                     r_valid_o,
  output logic [NB_CH-1:0]                     r_opc_o,
  output logic [NB_CH-1:0][DATA_WIDTH-1:0]     r_rdata_o,
  input  logic                                 clr_i,
  output logic                                 err_valid_o,
  output logic [ADDR_WIDTH-1:0]                err_addr_o,
  output logic [CH_W-1:0]                      err_ch_o,
  output logic                                 err_wen_o,
  output logic [CNT_WIDTH-1:0]                 err_cnt_o,
  output logic                                 irq_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic [NB_CH-1:0]     resp_valid;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic                 hit_any;
  err_info_t            hit_info;
  err_info_t            log_q;
  logic                 log_valid_q;
  logic                 valid_after_clr;
  logic                 valid_d;
  logic                 irq_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // No back-pressure: every request is accepted in the cycle it is raised.
  assign gnt_o = req_i;

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    tcdm_error_resp_pipe #(
      .LATENCY (RESP_LATENCY)
    ) i_resp_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (req_i[c]),
      .valid_o (resp_valid[c])
    );

    // Data bus is quiet between responses.
    assign r_rdata_o[c] = resp_valid[c] ? ERROR_RESPONSE : '0;

`ifndef SYNTHESIS
    // Every request reaching this block is already a decode miss; one with
    // unknown attributes points at a broken master and cannot be logged.
    always @(posedge clk_i) begin
      if (rst_ni && req_i[c]) begin
        assert (!$isunknown({add_i[c], wen_i[c]}))
          else $error("tcdm_error_slave_mc: ch %0d request with unknown add/wen, add=0x%h",
                      c, add_i[c]);
      end
    end
`endif
  end

  assign r_valid_o = resp_valid;
  assign r_opc_o   = resp_valid;

  // Popcount of requests and the lowest-index requester; scanning downward
  // lets the last hit written be the lowest channel.
  always_comb begin
    hit_cnt  = '0;
    hit_any  = 1'b0;
    hit_info = '0;
    for (int c = int'(NB_CH) - 1; c >= 0; c--) begin
      if (req_i[c]) begin
        hit_cnt       = hit_cnt + HIT_CNT_W'(1);
        hit_any       = 1'b1;
        hit_info.addr = MAX_ADDR_W'(add_i[c]);
        hit_info.ch   = CH_IDX_W'(c);
        hit_info.wen  = wen_i[c];
      end
    end
  end

  // A clear is applied before a same-cycle capture, so the log looks empty
  // to the new error and it is never lost; irq sees that as a fresh rise.
  assign valid_after_clr = log_valid_q & ~clr_i;
  assign valid_d         = valid_after_clr | hit_any;
  assign cnt_d           = CNT_WIDTH'(sat_add(clr_i ? 32'd0 : 32'(cnt_q),
                                              32'(hit_cnt), CNT_MAX));

  // Sticky first-error log, saturating counter and one-cycle irq.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      log_valid_q <= 1'b0;
      log_q       <= '0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      log_valid_q <= valid_d;
      irq_q       <= valid_d & ~valid_after_clr;
      cnt_q       <= cnt_d;
      if (hit_any && !valid_after_clr) begin
        log_q <= hit_info;
      end else if (clr_i) begin
        log_q <= '0;
      end
    end
  end

  assign err_valid_o = log_valid_q;
  assign err_addr_o  = log_q.addr[ADDR_WIDTH-1:0];
  assign err_ch_o    = log_q.ch[CH_W-1:0];
  assign err_wen_o   = log_q.wen;
  assign err_cnt_o   = cnt_q;
  assign irq_o       = irq_q;

`ifndef SYNTHESIS
  // Parameter ranges the package types and response pipe are built for.
  always @(posedge clk_i) begin
    assert (RESP_LATENCY >= 1 && RESP_LATENCY <= 4 && NB_CH >= 1 && NB_CH <= MAX_CH &&
            ADDR_WIDTH >= 1 && ADDR_WIDTH <= MAX_ADDR_W && CNT_WIDTH >= 1 && CNT_WIDTH <= 32)
      else $fatal(1, "tcdm_error_slave_mc: parameter out of range (NB_CH=%0d RESP_LATENCY=%0d)",
                  NB_CH, RESP_LATENCY);
  end

  // Bits of the log entry beyond this instance's address/channel width stay zero.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (((log_q.addr >> ADDR_WIDTH) == '0) && ((log_q.ch >> CH_W) == '0))
        else $error("tcdm_error_slave_mc: log entry has bits set above its width");
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_error_slave_mc.sv
// Scoreboard bench for tcdm_error_slave_mc: instance A (4 channels, latency 3)
// and instance B (1 channel, latency 1, 4-bit counter).
module tb_tcdm_error_slave_mc;

  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          cyc;
    logic        v;
    logic [31:0] addr;
    logic [1:0]  ch;
    logic        wen;
    logic [15:0] cnt;
    logic        irq;
  } log_exp_t;

  // Instance A signals
  logic             rst_a_n, clr_a;
  logic [3:0]       req_a, wen_a, gnt_a, rv_a, opc_a;
  logic [3:0][31:0] add_a, rdata_a;
  logic             ev_a, ewen_a, irq_a;
  logic [31:0]      eaddr_a;
  logic [1:0]       ech_a;
  logic [15:0]      ecnt_a;

  // Instance B signals
  logic             rst_b_n, clr_b;
  logic [0:0]       req_b, wen_b, gnt_b, rv_b, opc_b, ech_b;
  logic [0:0][31:0] add_b, rdata_b;
  logic             ev_b, ewen_b, irq_b;
  logic [31:0]      eaddr_b;
  logic [3:0]       ecnt_b;

  int       qa_resp[4][$];
  int       qb_resp[$];
  log_exp_t qa_log[$];
  log_exp_t qb_log[$];

  tcdm_error_slave_mc #(
    .NB_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ERROR_RESPONSE(ERR),
    .RESP_LATENCY(3), .CNT_WIDTH(16)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .req_i(req_a), .add_i(add_a), .wen_i(wen_a),
    .gnt_o(gnt_a), .r_valid_o(rv_a), .r_opc_o(opc_a), .r_rdata_o(rdata_a),
    .clr_i(clr_a), .err_valid_o(ev_a), .err_addr_o(eaddr_a), .err_ch_o(ech_a),
    .err_wen_o(ewen_a), .err_cnt_o(ecnt_a), .irq_o(irq_a)
  );

  tcdm_error_slave_mc #(
    .NB_CH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ERROR_RESPONSE(ERR),
    .RESP_LATENCY(1), .CNT_WIDTH(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .req_i(req_b), .add_i(add_b), .wen_i(wen_b),
    .gnt_o(gnt_b), .r_valid_o(rv_b), .r_opc_o(opc_b), .r_rdata_o(rdata_b),
    .clr_i(clr_b), .err_valid_o(ev_b), .err_addr_o(eaddr_b), .err_ch_o(ech_b),
    .err_wen_o(ewen_b), .err_cnt_o(ecnt_b), .irq_o(irq_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
  endtask

  // Monitor A: responses per channel against queued due cycles, log against queued entries.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_gnt", 64'(gnt_a), 64'(req_a));
      for (int c = 0; c < 4; c++) begin
        if (qa_resp[c].size() > 0 && qa_resp[c][0] == cyc) begin
          void'(qa_resp[c].pop_front());
          chk($sformatf("a_resp_valid[%0d]", c), 64'(rv_a[c]), 64'd1);
          chk($sformatf("a_resp_opc[%0d]", c), 64'(opc_a[c]), 64'd1);
          chk($sformatf("a_resp_rdata[%0d]", c), 64'(rdata_a[c]), 64'(ERR));
        end else begin
          chk($sformatf("a_idle_valid[%0d]", c), 64'(rv_a[c]), 64'd0);
          chk($sformatf("a_idle_opc[%0d]", c), 64'(opc_a[c]), 64'd0);
          chk($sformatf("a_idle_rdata[%0d]", c), 64'(rdata_a[c]), 64'd0);
        end
      end
      if (qa_log.size() > 0 && qa_log[0].cyc == cyc) begin
        log_exp_t e;
        e = qa_log.pop_front();
        chk("a_err_valid", 64'(ev_a), 64'(e.v));
        chk("a_err_addr", 64'(eaddr_a), 64'(e.addr));
        chk("a_err_ch", 64'(ech_a), 64'(e.ch));
        chk("a_err_wen", 64'(ewen_a), 64'(e.wen));
        chk("a_err_cnt", 64'(ecnt_a), 64'(e.cnt));
        chk("a_irq", 64'(irq_a), 64'(e.irq));
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (mon_en) begin
      chk("b_gnt", 64'(gnt_b), 64'(req_b));
      if (qb_resp.size() > 0 && qb_resp[0] == cyc) begin
        void'(qb_resp.pop_front());
        chk("b_resp_valid", 64'(rv_b), 64'd1);
        chk("b_resp_opc", 64'(opc_b), 64'd1);
        chk("b_resp_rdata", 64'(rdata_b), 64'(ERR));
      end else begin
        chk("b_idle_valid", 64'(rv_b), 64'd0);
        chk("b_idle_opc", 64'(opc_b), 64'd0);
        chk("b_idle_rdata", 64'(rdata_b), 64'd0);
      end
      if (qb_log.size() > 0 && qb_log[0].cyc == cyc) begin
        log_exp_t e;
        e = qb_log.pop_front();
        chk("b_err_valid", 64'(ev_b), 64'(e.v));
        chk("b_err_addr", 64'(eaddr_b), 64'(e.addr));
        chk("b_err_ch", 64'(ech_b), 64'd0);
        chk("b_err_wen", 64'(ewen_b), 64'(e.wen));
        chk("b_err_cnt", 64'(ecnt_b), 64'(e.cnt));
        chk("b_irq", 64'(irq_b), 64'(e.irq));
      end
    end
  end

  // Drive one cycle on A (channel c address = base + c*0x100) and queue the expected log for the next cycle.
  task automatic a_step(input logic rst_n, input logic [3:0] req, input logic [31:0] base,
                        input logic wen, input logic clr,
                        input logic ev, input logic [31:0] ea, input logic [1:0] ech,
                        input logic ew, input logic [15:0] ecnt, input logic eirq);
    log_exp_t e;
    rst_a_n = rst_n;
    req_a   = req;
    clr_a   = clr;
    for (int c = 0; c < 4; c++) begin
      add_a[c] = base + 32'(c) * 32'h100;
      wen_a[c] = wen;
    end
    for (int c = 0; c < 4; c++) begin
      if (!rst_n) begin
        while (qa_resp[c].size() > 0 && qa_resp[c][$] > cyc) void'(qa_resp[c].pop_back());
      end else if (req[c]) begin
        qa_resp[c].push_back(cyc + 3);
      end
    end
    e.cyc = cyc + 1; e.v = ev; e.addr = ea; e.ch = ech; e.wen = ew; e.cnt = ecnt; e.irq = eirq;
    qa_log.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic b_step(input logic rst_n, input logic req, input logic [31:0] addr,
                        input logic wen, input logic clr,
                        input logic ev, input logic [31:0] ea, input logic ew,
                        input logic [15:0] ecnt, input logic eirq);
    log_exp_t e;
    rst_b_n  = rst_n;
    req_b[0] = req;
    add_b[0] = addr;
    wen_b[0] = wen;
    clr_b    = clr;
    if (!rst_n) begin
      while (qb_resp.size() > 0 && qb_resp[$] > cyc) void'(qb_resp.pop_back());
    end else if (req) begin
      qb_resp.push_back(cyc + 1);
    end
    e.cyc = cyc + 1; e.v = ev; e.addr = ea; e.ch = 2'd0; e.wen = ew; e.cnt = ecnt; e.irq = eirq;
    qb_log.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a_n = 1'b0; req_a = '0; add_a = '0; wen_a = '0; clr_a = 1'b0;
    rst_b_n = 1'b0; req_b = '0; add_b = '0; wen_b = '0; clr_b = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // A: reset, then release
    a_step(0, 4'b0000, 32'h0, 0, 0,  0, 32'h0, 2'd0, 0, 16'd0, 0);
    a_step(0, 4'b0000, 32'h0, 0, 0,  0, 32'h0, 2'd0, 0, 16'd0, 0);
    a_step(1, 4'b0000, 32'h0, 0, 0,  0, 32'h0, 2'd0, 0, 16'd0, 0);
    a_step(1, 4'b0000, 32'h0, 0, 0,  0, 32'h0, 2'd0, 0, 16'd0, 0);
    // ch1 + ch3 reads together: lowest index (ch1, 0x1100) captured, count 2, irq
    a_step(1, 4'b1010, 32'h1000, 1, 0,  1, 32'h1100, 2'd1, 1, 16'd2, 1);
    a_step(1, 4'b0000, 32'h0, 0, 0,     1, 32'h1100, 2'd1, 1, 16'd2, 0);
    // later ch0 write: log sticky, count 3
    a_step(1, 4'b0001, 32'h3000, 0, 0,  1, 32'h1100, 2'd1, 1, 16'd3, 0);
    for (int i = 0; i < 3; i++)
      a_step(1, 4'b0000, 32'h0, 0, 0,   1, 32'h1100, 2'd1, 1, 16'd3, 0);
    // clear with no request
    a_step(1, 4'b0000, 32'h0, 0, 1,     0, 32'h0, 2'd0, 0, 16'd0, 0);
    // 10 back-to-back writes on ch2 (0x4200)
    for (int i = 0; i < 10; i++)
      a_step(1, 4'b0100, 32'h4000, 0, 0, 1, 32'h4200, 2'd2, 0, 16'(i + 1), (i == 0));
    a_step(1, 4'b0000, 32'h0, 0, 0,     1, 32'h4200, 2'd2, 0, 16'd10, 0);
    // clear together with a ch2 read at 0x2000: new error captured, count 1, fresh irq
    a_step(1, 4'b0100, 32'h1E00, 1, 1,  1, 32'h2000, 2'd2, 1, 16'd1, 1);
    a_step(1, 4'b0000, 32'h0, 0, 0,     1, 32'h2000, 2'd2, 1, 16'd1, 0);
    // all four channels at once
    a_step(1, 4'b1111, 32'h5000, 0, 0,  1, 32'h2000, 2'd2, 1, 16'd5, 0);
    for (int i = 0; i < 3; i++)
      a_step(1, 4'b0000, 32'h0, 0, 0,   1, 32'h2000, 2'd2, 1, 16'd5, 0);
    // ch0 request, then reset while its response is in flight: dropped
    a_step(1, 4'b0001, 32'h6000, 1, 0,  1, 32'h2000, 2'd2, 1, 16'd6, 0);
    a_step(0, 4'b0000, 32'h0, 0, 0,     0, 32'h0, 2'd0, 0, 16'd0, 0);
    a_step(0, 4'b0000, 32'h0, 0, 0,     0, 32'h0, 2'd0, 0, 16'd0, 0);
    for (int i = 0; i < 5; i++)
      a_step(1, 4'b0000, 32'h0, 0, 0,   0, 32'h0, 2'd0, 0, 16'd0, 0);

    // B: reset, release, single read at 0x1A10_0000
    b_step(0, 0, 32'h0, 0, 0,  0, 32'h0, 0, 16'd0, 0);
    b_step(1, 0, 32'h0, 0, 0,  0, 32'h0, 0, 16'd0, 0);
    b_step(1, 0, 32'h0, 0, 0,  0, 32'h0, 0, 16'd0, 0);
    b_step(1, 1, 32'h1A10_0000, 1, 0,  1, 32'h1A10_0000, 1, 16'd1, 1);
    // 19 more: 4-bit counter saturates at 15
    for (int i = 1; i < 20; i++)
      b_step(1, 1, 32'h1A10_0000 + 32'(4 * i), 1, 0,
             1, 32'h1A10_0000, 1, 16'((i + 1 > 15) ? 15 : i + 1), 0);
    b_step(1, 0, 32'h0, 0, 0,  1, 32'h1A10_0000, 1, 16'd15, 0);
    b_step(1, 0, 32'h0, 0, 1,  0, 32'h0, 0, 16'd0, 0);
    b_step(1, 1, 32'h1A10_0100, 0, 0,  1, 32'h1A10_0100, 0, 16'd1, 1);
    b_step(1, 0, 32'h0, 0, 0,  1, 32'h1A10_0100, 0, 16'd1, 0);
    b_step(1, 0, 32'h0, 0, 0,  1, 32'h1A10_0100, 0, 16'd1, 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
